mul4_gen: RTL
=============

Name: mul4_gen

Overview:
- Sequential generator for multiples of STEP (default 4): on a start pulse it latches a W_IN-bit operand k and produces o = k*STEP by repeated addition of STEP, one addition per clock.
- It is the generating counterpart of the combinational multiple-of-4 detector, which works by repeated subtraction. Its output can be fed straight into that detector, which must report 1 for every result.
- Uses a start/busy/done handshake for use as a small iterative arithmetic unit in the lab datapath.

Parameters:
- STEP, 4: constant added per iteration.
- W_IN, 4: operand width.
- W_OUT, 6: result width. Must satisfy (2^W_IN - 1)*STEP < 2^W_OUT; with the defaults, 15*4 = 60 < 64.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- i  input  W_IN  operand k, latched on the accepted start.
- busy  output  1  high while in ADD.
- done  output  1  one-cycle pulse in DONE; o is valid from this cycle on.
- o  output  W_OUT  result k*STEP; holds until the next DONE.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, o=0, internal cnt=0, acc=0. Reset overrides everything, including a start in the same cycle. Reset mid-ADD aborts the operation: no done pulse, o=0.
- busy and done are decoded from the state: busy = (state==ADD), done = (state==DONE).
- IDLE: if start=1, then cnt<=i, acc<=0, go to ADD. Otherwise stay. o unchanged.
- ADD:
  - If cnt==0: o<=acc, go to DONE.
  - Else: acc<=acc+STEP, cnt<=cnt-1, stay.
  - start is ignored, and i changes are ignored after latching.
- DONE: stay exactly one cycle, then IDLE unconditionally. start is ignored here, so back-to-back operations need start held or re-asserted in the following IDLE cycle.
- Latency: start accepted at edge E gives done=1 in the cycle after edge E+k+1, and o updates at that same edge.
  - k=0: done in the cycle after E+1, o=0.
  - k=15: done in the cycle after E+16, o=60.
- Throughput: one result per k+3 cycles (IDLE accept, ADD × (k+1), DONE).
- Arithmetic is unsigned. acc is W_OUT bits wide and cannot wrap given the parameter constraint. cnt is W_IN bits wide and never underflows, because the decrement happens only when cnt≠0.
- A start held high continuously restarts the block in every IDLE cycle, re-latching i each time.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: assert rst for 2 cycles with start=1 → busy=0, done=0, o=0, and no operation starts.
- Single op: i=3, start pulsed 1 cycle at edge E → busy high for 4 cycles, done=1 for exactly 1 cycle after edge E+4, o=12 and held afterward.
- Boundaries:
  - i=0 → done after edge E+1, o=0, busy high for 1 cycle.
  - i=15 → done after edge E+16, o=60.
- Ignored inputs: during a busy i=5 operation, pulse start and change i to 9 → o=20, a single done pulse, no restart.
- Sweep: for k=0..15, run sequentially and feed o into the multiple-of-4 detector → o==4k and detector output 1 at every done.
- Abort: start with i=10, assert rst 3 cycles later → next cycle busy=0, o=0, no done. A fresh start with i=2 then yields o=8.

Source files
------------

// File: rtl/mul4_gen.sv
// Iterative multiple-of-STEP generator: latches k on start and forms k*STEP
// by adding STEP once per clock, reporting through a start/busy/done handshake.
module mul4_gen #(
  parameter int STEP  = 4,
  parameter int W_IN  = 4,
  parameter int W_OUT = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W_IN-1:0]  i,
  output logic             busy,
  output logic             done,
  output logic [W_OUT-1:0] o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [W_OUT-1:0] STEP_W   = W_OUT'(STEP);
  localparam logic [W_IN-1:0]  CNT_ZERO = {W_IN{1'b0}};
  localparam logic [W_IN-1:0]  CNT_ONE  = W_IN'(1);
  localparam logic [W_OUT-1:0] ACC_ZERO = {W_OUT{1'b0}};

  state_t           state_q;
  logic [W_IN-1:0]  cnt_q;
  logic [W_OUT-1:0] acc_q;
  logic [W_OUT-1:0] o_q;
  logic             busy_q;
  logic             done_q;

  // Control FSM; busy/done are registered together with the state they decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      acc_q   <= ACC_ZERO;
      o_q     <= ACC_ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q   <= i;
            acc_q   <= ACC_ZERO;
            state_q <= ADD;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        ADD: begin
          // Decrement only while non-zero, so cnt can never underflow.
          if (cnt_q == CNT_ZERO) begin
            o_q     <= acc_q;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            acc_q   <= acc_q + STEP_W;
            cnt_q   <= cnt_q - CNT_ONE;
            state_q <= ADD;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign o    = o_q;

endmodule
